// File: rtl/controle_servo_multi_if.sv
// -----------------------------------------------------------------------------
// controle_servo_multi_if
//
// Bundles the command and PWM signals of the multi-channel servo controller.
//   posicao      N_CANAIS*POS_BITS  position codes, channel i at [i*POS_BITS +: POS_BITS]
//   habilita     N_CANAIS           per-channel output enable
//   controle     N_CANAIS           PWM outputs to the servos
//   db_controle  N_CANAIS           copy of controle for debug pins
//   pronto       N_CANAIS           channel settled (current width == target width)
//
// master: the command side (drives posicao/habilita, observes the outputs).
// slave : the controller itself.
// -----------------------------------------------------------------------------
interface controle_servo_multi_if #(
  parameter int N_CANAIS = 2,
  parameter int POS_BITS = 2
);

  logic [N_CANAIS*POS_BITS-1:0] posicao;
  logic [N_CANAIS-1:0]          habilita;
  logic [N_CANAIS-1:0]          controle;
  logic [N_CANAIS-1:0]          db_controle;
  logic [N_CANAIS-1:0]          pronto;

  modport master (
    output posicao,
    output habilita,
    input  controle,
    input  db_controle,
    input  pronto
  );

  modport slave (
    input  posicao,
    input  habilita,
    output controle,
    output db_controle,
    output pronto
  );

endinterface

// File: rtl/controle_servo_multi.sv
// -----------------------------------------------------------------------------
// controle_servo_multi
//
// N-channel servo PWM controller. One shared period counter runs 0..PERIODO-1.
// Each channel keeps its own pulse width, enable and settled flag; all of them
// update together on the edge that wraps the counter back to 0, so a pulse that
// is already in flight is never truncated or stretched by a command change.
// The width of every channel moves toward LARG_MIN + code*LARG_PASSO by at most
// RAMPA cycles per period (RAMPA = 0 jumps straight to the target).
//
// Ports:
//   clock  system clock
//   reset  asynchronous, active-low reset
//   bus    controle_servo_multi_if.slave (posicao, habilita in;
//          controle, db_controle, pronto out)
// -----------------------------------------------------------------------------
module controle_servo_multi #(
  parameter int N_CANAIS   = 2,
  parameter int POS_BITS   = 2,
  parameter int PERIODO    = 1000000,
  parameter int LARG_MIN   = 50000,
  parameter int LARG_PASSO = 16666,
  parameter int RAMPA      = 500
) (
  input  logic                   clock,
  input  logic                   reset,
  controle_servo_multi_if.slave  bus
);

  // Counter and widths share one width: a width may equal PERIODO (always high).
  localparam int W = $clog2(PERIODO + 1);

  localparam logic [W-1:0] ULTIMO   = W'(PERIODO - 1);
  localparam logic [W-1:0] LARG_INI = W'(LARG_MIN);

  // A step larger than the period can never be taken in full; clamping keeps
  // the constant inside W bits without changing behaviour.
  localparam bit           SEM_RAMPA = (RAMPA == 0);
  localparam int           RAMPA_LIM = (RAMPA > PERIODO) ? PERIODO : RAMPA;
  localparam logic [W-1:0] PASSO     = W'(RAMPA_LIM);

  logic [W-1:0]        contador;
  logic                fim_periodo;

  logic [W-1:0]        largura      [N_CANAIS];
  logic [W-1:0]        alvo         [N_CANAIS];
  logic [W-1:0]        largura_prox [N_CANAIS];
  logic [N_CANAIS-1:0] pronto_prox;

  logic [N_CANAIS-1:0] habilita_reg;
  logic [N_CANAIS-1:0] pronto_reg;
  logic [N_CANAIS-1:0] pwm;

  // The edge leaving PERIODO-1 is the only edge that samples the inputs.
  assign fim_periodo = (contador == ULTIMO);

  // ---------------------------------------------------------------------------
  // Shared period counter
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contador <= '0;
    end else if (fim_periodo) begin
      contador <= '0;
    end else begin
      contador <= contador + W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Target width per channel, computed in 32 bits and then narrowed; the legal
  // parameter range guarantees the result fits in W bits.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N_CANAIS; i++) begin
      alvo[i] = W'(LARG_MIN + LARG_PASSO * int'(bus.posicao[i*POS_BITS +: POS_BITS]));
    end
  end

  // ---------------------------------------------------------------------------
  // Slew-limited next width. The distance is taken as an unsigned magnitude
  // plus a direction bit, which avoids signed arithmetic on W-bit values.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [W-1:0] distancia;
    logic         sobe;
    // NOTE: every variable written here gets a value before any condition,
    // so no path leaves one holding its old value (no latch).
    distancia   = '0;
    sobe        = 1'b0;
    pronto_prox = '0;
    for (int i = 0; i < N_CANAIS; i++) begin
      largura_prox[i] = largura[i];
      sobe = (alvo[i] >= largura[i]);
      distancia = sobe ? (alvo[i] - largura[i]) : (largura[i] - alvo[i]);
      if (SEM_RAMPA || (distancia <= PASSO)) begin
        largura_prox[i] = alvo[i];
      end else if (sobe) begin
        largura_prox[i] = largura[i] + PASSO;
      end else begin
        largura_prox[i] = largura[i] - PASSO;
      end
      pronto_prox[i] = (largura_prox[i] == alvo[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel registers, all loaded together at the period wrap.
  // A disabled channel keeps ramping so re-enabling resumes at the ramped width.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      habilita_reg <= '0;
      pronto_reg   <= '1;
      // NOTE: this width array is a handful of flops, not a RAM, and the
      // first pulse after reset depends on it, so it is reset explicitly.
      for (int i = 0; i < N_CANAIS; i++) begin
        largura[i] <= LARG_INI;
      end
    end else if (fim_periodo) begin
      habilita_reg <= bus.habilita;
      pronto_reg   <= pronto_prox;
      for (int i = 0; i < N_CANAIS; i++) begin
        largura[i] <= largura_prox[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // PWM decode from registered values only. Reset clears habilita_reg
  // asynchronously, which forces every output low at once, even mid-pulse.
  // ---------------------------------------------------------------------------
  always_comb begin
    pwm = '0;
    for (int i = 0; i < N_CANAIS; i++) begin
      pwm[i] = habilita_reg[i] & (contador < largura[i]);
    end
  end

  assign bus.controle    = pwm;
  assign bus.db_controle = pwm;
  assign bus.pronto      = pronto_reg;

endmodule

// File: tb/tb_controle_servo_multi.sv
// -----------------------------------------------------------------------------
// tb_controle_servo_multi
//
// Two instances share clock and reset: dut_a with RAMPA=15 and dut_b with
// RAMPA=0 (N_CANAIS=2, POS_BITS=2, PERIODO=100, LARG_MIN=10, LARG_PASSO=20).
// A period-level reference model, written from the channel rules with integer
// arithmetic, is compared against both instances on every falling edge.
// A table of per-period records and a few hand-written sequences check pulse
// widths, pulse shape and pronto against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_controle_servo_multi;

  localparam int N  = 2;
  localparam int PB = 2;
  localparam int P  = 100;
  localparam int LM = 10;
  localparam int LP = 20;
  localparam int RA = 15;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  controle_servo_multi_if #(.N_CANAIS(N), .POS_BITS(PB)) bus_a ();
  controle_servo_multi_if #(.N_CANAIS(N), .POS_BITS(PB)) bus_b ();

  controle_servo_multi #(
    .N_CANAIS(N), .POS_BITS(PB), .PERIODO(P),
    .LARG_MIN(LM), .LARG_PASSO(LP), .RAMPA(RA)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  controle_servo_multi #(
    .N_CANAIS(N), .POS_BITS(PB), .PERIODO(P),
    .LARG_MIN(LM), .LARG_PASSO(LP), .RAMPA(0)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Parameter legality
  // ---------------------------------------------------------------------------
  initial begin
    if (LM + ((2 ** PB) - 1) * LP > P) begin
      $display("FAIL param_range: max width %0d exceeds period %0d", LM + ((2 ** PB) - 1) * LP, P);
      $fatal(1, "illegal parameter set");
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: position in the period plus, per channel, the width,
  // enable and settled flag that hold for the current period.
  // ---------------------------------------------------------------------------
  int pos;
  int ma_w [N];
  int mb_w [N];
  bit ma_h [N];
  bit mb_h [N];
  bit ma_p [N];
  bit mb_p [N];

  function automatic int target(input logic [N*PB-1:0] p, input int ch);
    logic [PB-1:0] c;
    c = p[ch*PB +: PB];
    return LM + int'(c) * LP;
  endfunction

  function automatic int next_width(input int cur, input int tgt, input int rampa);
    int d;
    d = tgt - cur;
    if (rampa == 0 || (d <= rampa && d >= -rampa)) return tgt;
    return (d > 0) ? cur + rampa : cur - rampa;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos <= 0;
      for (int i = 0; i < N; i++) begin
        ma_w[i] <= LM; mb_w[i] <= LM;
        ma_h[i] <= 1'b0; mb_h[i] <= 1'b0;
        ma_p[i] <= 1'b1; mb_p[i] <= 1'b1;
      end
    end else begin
      pos <= (pos == P - 1) ? 0 : pos + 1;
      if (pos == P - 1) begin
        for (int i = 0; i < N; i++) begin
          ma_w[i] <= next_width(ma_w[i], target(bus_a.posicao, i), RA);
          mb_w[i] <= next_width(mb_w[i], target(bus_b.posicao, i), 0);
          ma_p[i] <= (next_width(ma_w[i], target(bus_a.posicao, i), RA) == target(bus_a.posicao, i));
          mb_p[i] <= (next_width(mb_w[i], target(bus_b.posicao, i), 0) == target(bus_b.posicao, i));
          ma_h[i] <= bus_a.habilita[i];
          mb_h[i] <= bus_b.habilita[i];
        end
      end
    end
  end

  logic [N-1:0] ea_c, ea_p, eb_c, eb_p;
  always_comb begin
    ea_c = '0; ea_p = '0; eb_c = '0; eb_p = '0;
    for (int i = 0; i < N; i++) begin
      ea_c[i] = ma_h[i] && (pos < ma_w[i]);
      eb_c[i] = mb_h[i] && (pos < mb_w[i]);
      ea_p[i] = ma_p[i];
      eb_p[i] = mb_p[i];
    end
  end

  always @(negedge clock) begin
    check("a_controle",    bus_a.controle,    ea_c);
    check("a_db_controle", bus_a.db_controle, ea_c);
    check("a_pronto",      bus_a.pronto,      ea_p);
    check("b_controle",    bus_b.controle,    eb_c);
    check("b_db_controle", bus_b.db_controle, eb_c);
    check("b_pronto",      bus_b.pronto,      eb_p);
  end

  // ---------------------------------------------------------------------------
  // Period measurement. Called at #1 after a period-start edge; returns at #1
  // after the next one. Widths count high cycles; shape_err counts any high
  // cycle not contiguous with counter 0. Optionally changes dut_a inputs when
  // the counter reaches chg_at.
  // ---------------------------------------------------------------------------
  int           wa [N];
  int           wb [N];
  logic [N-1:0] pa, pbr;
  int           shape_err;

  task automatic run_period(input int chg_at, input logic [N*PB-1:0] np, input logic [N-1:0] nh);
    pa  = bus_a.pronto;
    pbr = bus_b.pronto;
    shape_err = 0;
    for (int i = 0; i < N; i++) begin
      wa[i] = 0;
      wb[i] = 0;
    end
    for (int k = 0; k < P; k++) begin
      if (k == chg_at) begin
        bus_a.posicao  = np;
        bus_a.habilita = nh;
      end
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        if (bus_a.controle[i] === 1'b1) begin
          if (wa[i] != k) shape_err++;
          wa[i]++;
        end
        if (bus_b.controle[i] === 1'b1) begin
          if (wb[i] != k) shape_err++;
          wb[i]++;
        end
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic expect_a(input string tag, input int w0, input int w1, input logic [N-1:0] pr);
    check({tag, "_a_w0"},    wa[0],     w0);
    check({tag, "_a_w1"},    wa[1],     w1);
    check({tag, "_a_pronto"}, pa,       pr);
    check({tag, "_shape"},   shape_err, 0);
  endtask

  task automatic expect_b(input string tag, input int w0, input int w1, input logic [N-1:0] pr);
    check({tag, "_b_w0"},     wb[0], w0);
    check({tag, "_b_w1"},     wb[1], w1);
    check({tag, "_b_pronto"}, pbr,   pr);
  endtask

  // One record per period: the pulse widths and pronto observed in that
  // period, and the inputs presented during it (they take effect next period).
  typedef struct {
    logic [N*PB-1:0] pos;
    logic [N-1:0]    hab;
    int              w0;
    int              w1;
    logic [N-1:0]    pr;
  } row_t;

  row_t tab [17];

  initial begin
    tab[0]  = '{4'b0000, 2'b00,  0,  0, 2'b11};
    tab[1]  = '{4'b0000, 2'b00,  0,  0, 2'b11};
    tab[2]  = '{4'b0000, 2'b11,  0,  0, 2'b11};
    tab[3]  = '{4'b0011, 2'b11, 10, 10, 2'b11};
    tab[4]  = '{4'b0011, 2'b11, 25, 10, 2'b10};
    tab[5]  = '{4'b0011, 2'b11, 40, 10, 2'b10};
    tab[6]  = '{4'b0011, 2'b11, 55, 10, 2'b10};
    tab[7]  = '{4'b0000, 2'b11, 70, 10, 2'b11};
    tab[8]  = '{4'b0000, 2'b11, 55, 10, 2'b10};
    tab[9]  = '{4'b0000, 2'b11, 40, 10, 2'b10};
    tab[10] = '{4'b0000, 2'b11, 25, 10, 2'b10};
    tab[11] = '{4'b1000, 2'b11, 10, 10, 2'b11};
    tab[12] = '{4'b1000, 2'b11, 10, 25, 2'b01};
    tab[13] = '{4'b1000, 2'b10, 10, 40, 2'b01};
    tab[14] = '{4'b1000, 2'b11,  0, 50, 2'b11};
    tab[15] = '{4'b0000, 2'b11, 10, 50, 2'b11};
    tab[16] = '{4'b0000, 2'b11, 10, 35, 2'b01};

    bus_a.posicao  = '0;
    bus_a.habilita = '0;
    bus_b.posicao  = '0;
    bus_b.habilita = 2'b11;

    // Reset state
    #1 reset = 1'b0;
    @(posedge clock); #1;
    check("rst_controle",    bus_a.controle,    2'b00);
    check("rst_db_controle", bus_a.db_controle, 2'b00);
    check("rst_pronto",      bus_a.pronto,      2'b11);
    @(posedge clock); #1;
    reset = 1'b1;

    // Table-driven periods
    for (int r = 0; r < 17; r++) begin
      run_period(0, tab[r].pos, tab[r].hab);
      expect_a($sformatf("row%0d", r), tab[r].w0, tab[r].w1, tab[r].pr);
    end

    // Posicao changed mid-period while ch0 ramps up at width 40
    run_period(0, 4'b0011, 2'b11);
    expect_a("mid_p0", 10, 20, 2'b01);
    run_period(-1, 4'b0011, 2'b11);
    expect_a("mid_p1", 25, 10, 2'b10);
    run_period(20, 4'b0001, 2'b11);
    expect_a("mid_p2", 40, 10, 2'b10);
    run_period(0, 4'b0011, 2'b11);
    expect_a("mid_p3", 30, 10, 2'b11);

    // habilita[0] dropped at counter 5 with width 70, then re-enabled
    run_period(-1, 4'b0011, 2'b11);
    expect_a("hab_p0", 45, 10, 2'b10);
    run_period(-1, 4'b0011, 2'b11);
    expect_a("hab_p1", 60, 10, 2'b10);
    run_period(5, 4'b0011, 2'b10);
    expect_a("hab_p2", 70, 10, 2'b11);
    run_period(0, 4'b0011, 2'b11);
    expect_a("hab_p3", 0, 10, 2'b11);
    run_period(-1, 4'b0011, 2'b11);
    expect_a("hab_p4", 70, 10, 2'b11);

    // Reset asserted mid-pulse at counter 30
    for (int k = 0; k < 30; k++) begin
      @(posedge clock); #1;
    end
    check("pre_rst_high", bus_a.controle, 2'b01);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_controle", bus_a.controle,    2'b00);
    check("rst_mid_db",       bus_a.db_controle, 2'b00);
    check("rst_mid_pronto",   bus_a.pronto,      2'b11);
    check("rst_mid_b_ctrl",   bus_b.controle,    2'b00);
    @(posedge clock); @(posedge clock); #1;
    check("rst_hold_controle", bus_a.controle, 2'b00);
    reset = 1'b1;

    // After release: one silent period, then ramp resumes from LARG_MIN.
    // dut_b (no ramp) jumps from 10 to 70 in a single period.
    run_period(-1, 4'b0011, 2'b11);
    expect_a("post_rst_p0", 0, 0, 2'b11);
    expect_b("post_rst_p0", 0, 0, 2'b11);
    bus_b.posicao = 4'b0011;
    run_period(-1, 4'b0011, 2'b11);
    expect_a("post_rst_p1", 25, 10, 2'b10);
    expect_b("jump_p0", 10, 10, 2'b11);
    run_period(-1, 4'b0011, 2'b11);
    expect_a("post_rst_p2", 40, 10, 2'b10);
    expect_b("jump_p1", 70, 10, 2'b11);

    // Randomized phase, checked cycle by cycle against the model
    for (int c = 0; c < 2500; c++) begin
      @(posedge clock); #1;
      if ($urandom_range(0, 29) == 0) bus_a.posicao  = 4'($urandom);
      if ($urandom_range(0, 59) == 0) bus_a.habilita = 2'($urandom);
      if ($urandom_range(0, 29) == 0) bus_b.posicao  = 4'($urandom);
      if ($urandom_range(0, 59) == 0) bus_b.habilita = 2'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
      end
    end

    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/controle_servo_multi.md
# controle_servo_multi

Parametrised N-channel servo controller. Each channel has one PWM output. Each channel's pulse width is selected by a position code, and a per-period slew limit ramps the pulse width toward its target instead of jumping. The block replaces the single-channel, fixed-table servo controller: one shared period counter drives all channels, and each channel holds its own current-width register, enable and settled flag. It sits between the position/command logic and the servo pins.

## Interface
- N_CANAIS, 2, number of servo channels
- POS_BITS, 2, bits per channel position code
- PERIODO, 1000000, PWM period in clock cycles (20 ms at 50 MHz)
- LARG_MIN, 50000, pulse width for code 0 (1 ms)
- LARG_PASSO, 16666, width increment per code step
- RAMPA, 500, maximum width change per period in cycles; 0 disables ramping (immediate jump)
- clock  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-low reset
- posicao  input  N_CANAIS*POS_BITS  position codes; channel i occupies bits [i*POS_BITS +: POS_BITS]
- habilita  input  N_CANAIS  per-channel output enable
- controle  output  N_CANAIS  PWM outputs to servos
- db_controle  output  N_CANAIS  copy of controle for debug pins
- pronto  output  N_CANAIS  channel settled: current width equals target width

## Operation
- Arithmetic widths:
  - Counter and width registers are $clog2(PERIODO+1) bits.
  - Target width is LARG_MIN + posicao_i*LARG_PASSO, computed at full width.
  - Legal parameter range requires LARG_MIN + (2^POS_BITS-1)*LARG_PASSO <= PERIODO. The bench checks this at elaboration.
- Period counter:
  - Counts 0..PERIODO-1 and wraps to 0.
  - The "period start" is the cycle in which the counter equals 0.
- Register updates happen only on the edge that loads counter=0, i.e. the edge leaving counter=PERIODO-1. On that edge, for each channel i:
  - habilita_reg[i] <= habilita[i].
  - alvo = LARG_MIN + posicao_i*LARG_PASSO.
  - d = alvo - largura[i] (signed).
  - If RAMPA==0 or |d| <= RAMPA: largura[i] <= alvo.
  - Otherwise: largura[i] <= largura[i] ± RAMPA, stepping toward alvo.
  - pronto[i] <= (new largura[i] == alvo).
- Inputs outside that edge are ignored. Mid-period changes to posicao or habilita never truncate or extend the current pulse.
- Output: controle[i] = habilita_reg[i] & (contador < largura[i]). This is decoded from registered values only, so it has no glitches.
- db_controle = controle.
- A disabled channel drives 0 but still ramps largura toward its target, so re-enabling resumes at the ramped width.
- Channels are fully independent. Simultaneous updates on all channels are required at every period start.
- Reset (reset=0, asynchronous):
  - contador=0, largura[i]=LARG_MIN, habilita_reg=0, pronto=all 1s.
  - controle=0 and db_controle=0 immediately, including mid-pulse.
- Reset release: counter runs from 0.
  - The first period after release produces no pulse, because habilita_reg=0.
  - The first edge that sees counter wrap samples the inputs.

## Timing
- Pulse of period k:
  - Rises in the first cycle of the period (counter=0), if largura>0 and the channel is enabled.
  - Lasts exactly largura[i] cycles.
  - Falls when counter reaches largura[i].
- If largura == PERIODO, the output stays high for the whole period.
- Input-to-output latency:
  - A change settled before the period-start edge affects that same period.
  - A change arriving later affects the next period.
- Ramp duration from width w0 to target t is ceil(|t-w0|/RAMPA) periods. pronto rises on the period-start edge where the final step lands.
- pronto changes only on period-start edges, except when reset forces it.

## Test plan
All scenarios use N_CANAIS=2, POS_BITS=2, PERIODO=100, LARG_MIN=10, LARG_PASSO=20, RAMPA=15 unless a scenario states otherwise.
- Reset, and reset released with habilita=00 -> controle=00, pronto=11, and no pulse for 3 full periods.
- habilita=11 and posicao=0 from t=0 -> first period has no pulse. Every later period: both channels high for exactly 10 cycles starting at counter=0.
- Channel 0 posicao 0→3 (target 70) -> ch0 widths 25, 40, 55, 70 in successive periods. pronto[0] reads 0, 0, 0, 1. Ch1 stays at 10 with pronto[1]=1.
- Ch0 at width 40 ramping up, posicao changed to 1 (target 30) mid-period -> current 40-cycle pulse completes. Next period width is 30 and pronto[0]=1.
- habilita[0] dropped at counter=5 while width=70 -> current pulse is still 70 cycles. Next period has no pulse. Re-enable returns width 70 with no ramp.
- RAMPA=0 instance, posicao 0→3 -> width jumps 10→70 in one period. Separately, reset asserted at counter=30 mid-pulse -> controle=0 in the same cycle, and the reset state is restored.
